// File: rtl/ternary_dot_pkg.sv
// ternary_dot_pkg
// Shared definitions for the ternary dot-product tile feeder:
//   - ternary weight codes as carried on the host-side element stream
//   - bit positions of the control fields on the tile's uio_in bus
//   - feeder FSM state encoding
//   - saturating helper for the optional golden accumulator
//     (TERNARY_DOT_FEEDER_CHECK_EN)
package ternary_dot_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;
  localparam logic [1:0] W_RSVD = 2'b10;

  localparam int UIO_WNZ   = 0;
  localparam int UIO_WNEG  = 1;
  localparam int UIO_FIRST = 2;
  localparam int UIO_LAST  = 3;

  // The tile result is 15 bits wide; the golden model clamps to that range.
  localparam int ACC_LIMIT = 16383;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } feeder_state_t;

  function automatic logic signed [15:0] sat_acc(input logic signed [17:0] v);
    if (v > 18'(ACC_LIMIT)) begin
      return 16'(ACC_LIMIT);
    end else if (v < -18'(ACC_LIMIT)) begin
      return -16'(ACC_LIMIT);
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/ternary_weight_enc.sv
// ternary_weight_enc
// Combinational decode of a 2-bit ternary weight code into the tile's
// control bits. The reserved code decodes as a zero weight and raises rsvd.
// Ports:
//   code   in  2  weight code (00=0, 01=+1, 11=-1, 10=reserved)
//   w_nz   out 1  weight is non-zero
//   w_neg  out 1  weight is negative
//   rsvd   out 1  reserved code seen
module ternary_weight_enc
  import ternary_dot_pkg::*;
(
  input  logic [1:0] code,
  output logic       w_nz,
  output logic       w_neg,
  output logic       rsvd
);

  always_comb begin
    w_nz  = 1'b0;
    w_neg = 1'b0;
    rsvd  = 1'b0;
    case (code)
      W_POS:  w_nz = 1'b1;
      W_NEG: begin
        w_nz  = 1'b1;
        w_neg = 1'b1;
      end
      W_RSVD: rsvd = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ternary_dot_feeder.sv
// ternary_dot_feeder
// Host-side transmitter/collector for the ternary dot-product tile. Elements
// (weight, activation) are driven one per cycle onto the tile pins; after the
// last element the feeder waits out the tile latency, captures the 16-bit
// sign-extended result and offers it on the result port.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds data stable while valid is high and not yet
// accepted; ready never depends combinationally on valid (both ready/valid
// outputs here are registered).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     element stream handshake
//   in_act, in_w, in_last element: int8 activation, ternary code, end marker
//   dot_ui_in, dot_uio_in registered drive to the tile (act; wnz/wneg/first/last)
//   dot_uo_out, dot_uio_out tile outputs
//   res_valid/res_ready   result handshake, res_data signed 16-bit result
//   err_code, err_len     sticky error flags (reserved code, length overrun)
//   chk_mismatch          only with TERNARY_DOT_FEEDER_CHECK_EN: one-cycle
//                         pulse when the captured result differs from the
//                         local golden sum
//   dbg_state             current FSM state
module ternary_dot_feeder
  import ternary_dot_pkg::*;
#(
  parameter int MAX_LEN     = 256,
  parameter int DOT_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_act,
  input  logic [1:0]  in_w,
  input  logic        in_last,
  output logic [7:0]  dot_ui_in,
  output logic [7:0]  dot_uio_in,
  input  logic [7:0]  dot_uo_out,
  input  logic [7:0]  dot_uio_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        err_code,
  output logic        err_len,
`ifdef TERNARY_DOT_FEEDER_CHECK_EN
  output logic        chk_mismatch,
`endif
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(MAX_LEN) + 1;
  localparam int LAT_W = (DOT_LATENCY > 1) ? $clog2(DOT_LATENCY) : 1;

  feeder_state_t    state;
  logic [CNT_W-1:0] elem_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             w_nz, w_neg, w_rsvd;
  logic             accept, hit_max, ends_vec, capture;
  logic [7:0]       elem_pins;
  logic [15:0]      tile_result;
  logic             unused_uio0;

  ternary_weight_enc u_enc (
    .code  (in_w),
    .w_nz  (w_nz),
    .w_neg (w_neg),
    .rsvd  (w_rsvd)
  );

  // Tile result is 15 bits: uio_out[7:1] hold bits 14:8, bit 0 carries nothing.
  assign tile_result = {dot_uio_out[7], dot_uio_out[7:1], dot_uo_out};
  assign unused_uio0 = dot_uio_out[0];
  assign dbg_state   = state;

  always_comb begin
    accept   = in_valid && in_ready && (state == IDLE || state == STREAM);
    hit_max  = (elem_cnt + CNT_W'(1)) == CNT_W'(MAX_LEN);
    ends_vec = in_last || hit_max;
    // lat_cnt is loaded on the cycle the last element sits on the pins, so
    // reaching zero afterwards lands exactly on the tile's valid cycle.
    capture  = (state == WAIT) && !dot_uio_in[UIO_LAST] && (lat_cnt == '0);
    elem_pins            = '0;
    elem_pins[UIO_WNZ]   = w_nz;
    elem_pins[UIO_WNEG]  = w_neg;
    elem_pins[UIO_FIRST] = (state == IDLE);
    elem_pins[UIO_LAST]  = ends_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      elem_cnt   <= '0;
      lat_cnt    <= '0;
      in_ready   <= 1'b0;
      dot_ui_in  <= '0;
      dot_uio_in <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      err_code   <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      // Pins idle at zero unless an element is accepted this cycle.
      dot_ui_in  <= '0;
      dot_uio_in <= '0;
      if (accept) begin
        dot_ui_in  <= in_act;
        dot_uio_in <= elem_pins;
        elem_cnt   <= elem_cnt + 1'b1;
        if (w_rsvd) err_code <= 1'b1;
        if (hit_max && !in_last) err_len <= 1'b1;
      end
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (ends_vec) begin
              state    <= WAIT;
              in_ready <= 1'b0;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept && ends_vec) begin
            state    <= WAIT;
            in_ready <= 1'b0;
          end
        end
        WAIT: begin
          if (dot_uio_in[UIO_LAST]) begin
            lat_cnt <= LAT_W'(DOT_LATENCY - 1);
          end else if (capture) begin
            state     <= HOLD;
            res_valid <= 1'b1;
            res_data  <= tile_result;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            elem_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TERNARY_DOT_FEEDER_CHECK_EN
  logic signed [15:0] gold_acc;
  logic signed [17:0] act_ext, term, gold_sum;

  always_comb begin
    act_ext  = {{10{in_act[7]}}, in_act};
    term     = w_nz ? (w_neg ? -act_ext : act_ext) : '0;
    // The first element of a vector starts a fresh sum.
    gold_sum = ((state == IDLE) ? 18'sd0 : {{2{gold_acc[15]}}, gold_acc}) + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gold_acc     <= '0;
      chk_mismatch <= 1'b0;
    end else begin
      chk_mismatch <= 1'b0;
      if (accept) begin
        gold_acc <= sat_acc(gold_sum);
      end else if (state == HOLD && res_ready) begin
        gold_acc <= '0;
      end
      if (capture) chk_mismatch <= (tile_result != gold_acc);
    end
  end
`endif

endmodule

// File: tb/tb_ternary_dot_feeder.sv
`timescale 1ns/1ps
module tb_ternary_dot_feeder;

  localparam int MAX_LEN     = 4;
  localparam int DOT_LATENCY = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_act   = 8'd0;
  logic [1:0]  in_w     = 2'd0;
  logic        in_last  = 1'b0;
  logic [7:0]  dot_ui_in, dot_uio_in, dot_uo_out, dot_uio_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        err_code, err_len;
  logic [1:0]  dbg_state;
`ifdef TERNARY_DOT_FEEDER_CHECK_EN
  logic        chk_mismatch;
`endif

  int checks = 0;
  int errors = 0;

  ternary_dot_feeder #(.MAX_LEN(MAX_LEN), .DOT_LATENCY(DOT_LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_act       (in_act),
    .in_w         (in_w),
    .in_last      (in_last),
    .dot_ui_in    (dot_ui_in),
    .dot_uio_in   (dot_uio_in),
    .dot_uo_out   (dot_uo_out),
    .dot_uio_out  (dot_uio_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .err_code     (err_code),
    .err_len      (err_len),
`ifdef TERNARY_DOT_FEEDER_CHECK_EN
    .chk_mismatch (chk_mismatch),
`endif
    .dbg_state    (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- tile model ----------------
  // Accumulates signed w*act from the pins; the result becomes visible
  // DOT_LATENCY cycles after the cycle 'last' is on the pins. Outside that
  // window the outputs carry filler so a mistimed capture shows up.
  int         tile_acc;
  logic [14:0] tile_pipe [DOT_LATENCY];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_acc = 0;
      for (int i = 0; i < DOT_LATENCY; i++) tile_pipe[i] <= 15'h2A5A;
    end else begin
      if (dot_uio_in[2]) tile_acc = 0;
      if (dot_uio_in[0])
        tile_acc = dot_uio_in[1] ? tile_acc - int'($signed(dot_ui_in))
                                 : tile_acc + int'($signed(dot_ui_in));
      tile_pipe[0] <= dot_uio_in[3] ? tile_acc[14:0] : 15'h2A5A;
      for (int i = 1; i < DOT_LATENCY; i++) tile_pipe[i] <= tile_pipe[i-1];
    end
  end
  assign dot_uo_out  = tile_pipe[DOT_LATENCY-1][7:0];
  assign dot_uio_out = {tile_pipe[DOT_LATENCY-1][14:8], 1'b0};

  // ---------------- behavioural model / scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [7:0]  exp_ui, exp_uio;
  logic        exp_err_code, exp_err_len;
  int          vec_cnt, vec_sum, cyc = 0, last_cyc = 0, m_w;
  logic        m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ui = 0; exp_uio = 0; exp_err_code = 0; exp_err_len = 0;
      vec_cnt = 0; vec_sum = 0;
      exp_q.delete();
    end else begin
      cyc++;
      exp_ui = 0;
      exp_uio = 0;
      if (res_valid && res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        m_w = (in_w == 2'b01) ? 1 : (in_w == 2'b11) ? -1 : 0;
        m_last = in_last || (vec_cnt + 1 == MAX_LEN);
        if (in_w == 2'b10) exp_err_code = 1;
        if (!in_last && vec_cnt + 1 == MAX_LEN) exp_err_len = 1;
        exp_ui = in_act;
        exp_uio = {4'b0, m_last, (vec_cnt == 0), (m_w < 0), (m_w != 0)};
        vec_sum += m_w * int'($signed(in_act));
        vec_cnt++;
        if (m_last) begin
          exp_q.push_back(16'(vec_sum));
          vec_cnt = 0;
          vec_sum = 0;
          last_cyc = cyc;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        prev_valid = 1'b0;
  logic [15:0] prev_data  = 16'd0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("dot_ui_in", dot_ui_in, exp_ui);
      chk("dot_uio_in", dot_uio_in, exp_uio);
      chk("err_code", err_code, exp_err_code);
      chk("err_len", err_len, exp_err_len);
`ifdef TERNARY_DOT_FEEDER_CHECK_EN
      chk("chk_mismatch", chk_mismatch, 0);
`endif
      if (res_valid) begin
        chk("res_sign_ext", res_data[15], res_data[14]);
        chk("in_ready_while_result", in_ready, 0);
        if (!prev_valid) begin
          chk("res_latency", cyc - last_cyc, DOT_LATENCY + 1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL res_unexpected actual=%0h required=none", res_data);
          end else begin
            chk("res_data", res_data, exp_q[0]);
          end
        end else begin
          chk("res_stable", res_data, prev_data);
        end
      end
      prev_valid = res_valid;
      prev_data  = res_data;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] act, input logic [1:0] w, input logic last,
                      input logic [3:0] exp_nib);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1; in_act = act; in_w = w; in_last = last;
    while (!done && n < 40) begin
      @(posedge clk);
      if (in_ready) done = 1;
      n++;
    end
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end else begin
      chk("pins_nibble", dot_uio_in[3:0], exp_nib);
    end
  endtask

  task automatic collect(input int hold, input logic [15:0] exp, input string name);
    int n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_result required=%0h", name, exp);
    end else begin
      chk(name, res_data, exp);
      repeat (hold) begin
        @(negedge clk);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_res_valid", res_valid, 1);
        chk("hold_res_data", res_data, exp);
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk("res_valid_drop", res_valid, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dot_ui_in"}, dot_ui_in, 0);
    chk({tag, "_dot_uio_in"}, dot_uio_in, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_err_len"}, err_len, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #2 rst_n = 1'b1;

    // 4 elements: 10*1 + 20*(-1) + 30*0 + 40*1 = 30
    send(8'd10, 2'b01, 1'b0, 4'b0101);
    send(8'd20, 2'b11, 1'b0, 4'b0011);
    send(8'd30, 2'b00, 1'b0, 4'b0000);
    send(8'd40, 2'b01, 1'b1, 4'b1001);
    collect(0, 16'd30, "res_vec4");

    // single element: -1 * -128 = 128
    send(8'h80, 2'b11, 1'b1, 4'b1111);
    collect(0, 16'h0080, "res_single");

    // bubble between elements, then backpressure: 5 - 7 = -2
    send(8'd5, 2'b01, 1'b0, 4'b0101);
    @(posedge clk); #1;
    chk("bubble_uio", dot_uio_in, 0);
    chk("bubble_ui", dot_ui_in, 0);
    send(8'd7, 2'b11, 1'b1, 4'b1011);
    collect(5, 16'hFFFE, "res_backpressure");

    // reserved code counts as zero weight: 50*0 + 3 = 3
    send(8'd50, 2'b10, 1'b0, 4'b0100);
    chk("err_code_set", err_code, 1);
    send(8'd3, 2'b01, 1'b1, 4'b1001);
    collect(0, 16'd3, "res_rsvd");
    send(8'hFC, 2'b01, 1'b1, 4'b1101);
    collect(0, 16'hFFFC, "res_after_rsvd");
    chk("err_code_sticky", err_code, 1);

    // length guard: 4th element forced last, 5th waits for the next vector
    send(8'd1, 2'b01, 1'b0, 4'b0101);
    send(8'd2, 2'b01, 1'b0, 4'b0001);
    send(8'd3, 2'b01, 1'b0, 4'b0001);
    send(8'd4, 2'b01, 1'b0, 4'b1001);
    chk("err_len_set", err_len, 1);
    in_valid = 1'b1; in_act = 8'd9; in_w = 2'b01; in_last = 1'b1;
    chk("fifth_blocked", in_ready, 0);
    collect(3, 16'd10, "res_len_guard");
    send(8'd9, 2'b01, 1'b1, 4'b1101);
    collect(0, 16'd9, "res_fifth");

    // reset mid-vector
    send(8'd11, 2'b01, 1'b0, 4'b0101);
    send(8'd12, 2'b01, 1'b0, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send(8'hFD, 2'b11, 1'b1, 4'b1111);
    collect(0, 16'd3, "res_after_reset");
    chk("err_code_cleared", err_code, 0);
    chk("err_len_cleared", err_len, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
